// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants and types used by the fetch stage.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0040_0000;

    // One instruction-buffer entry: the word together with the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; entry 0 is always the head, so the head is a plain register.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    wr_idx;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // A simultaneous pop shifts everything down one slot, so the write lands one lower.
    assign wr_idx  = do_pop ? count - CW'(1) : count;
    assign head    = mem[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem[i] <= mem[i+1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && (wr_idx == CW'(i))) begin
                mem[i] <= push_data;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RISC-V IF stage: owns the PC, issues instruction-memory requests, buffers returned words
// and presents the head instruction to IF/ID; handles stalls, redirects and variable latency.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            valid_o,
    output logic [XLEN-1:0] PC_o,
    output logic [XLEN-1:0] PC_p4_o,
    output logic [XLEN-1:0] Instruction_o,
    output logic            misalign_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   buf_count;
    logic [CW-1:0]   pend_count;
    logic            buf_full;
    logic            buf_empty;
    logic            pend_full;
    logic            pend_empty;
    logic [XLEN-1:0] pend_head;
    fetch_entry_t    buf_head;
    fetch_entry_t    buf_entry;
    logic            handshake;
    logic            accept_rsp;
    logic            pop_head;
    logic [CW:0]     occupancy;
    logic            unused_fifo_status;

    assign unused_fifo_status = ^{buf_full, pend_full, pend_empty, pend_count};

    // Issue: the slot freed by this cycle's pop may be reused at once, keeping 1 instr/cycle.
    assign pop_head    = !buf_empty && !stall_i;
    assign occupancy   = {1'b0, outstanding} + {1'b0, buf_count} - {{CW{1'b0}}, pop_head};
    assign imem_req_o  = (occupancy < (CW+1)'(DEPTH));
    assign imem_addr_o = fetch_pc;
    assign handshake   = imem_req_o && imem_gnt_i;

    // Response: words still owed to a squashed stream are dropped instead of buffered.
    assign accept_rsp       = imem_rvalid_i && (discard == '0) && !redirect_i;
    assign outstanding_next = outstanding + CW'(handshake) - CW'(imem_rvalid_i);
    assign buf_entry        = '{pc: pend_head, instr: imem_rdata_i};

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            misalign_o  <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            misalign_o  <= redirect_i && (|redirect_pc_i[1:0]);
            if (redirect_i) begin
                fetch_pc <= word_align(redirect_pc_i);
                discard  <= outstanding_next;
            end else begin
                if (handshake) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_rvalid_i && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pending (
        .clk       (clk_i),
        .rst_n     (reset_i),
        .push      (handshake),
        .push_data (fetch_pc),
        .pop       (accept_rsp),
        .flush     (redirect_i),
        .full      (pend_full),
        .empty     (pend_empty),
        .count     (pend_count),
        .head      (pend_head)
    );

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clk       (clk_i),
        .rst_n     (reset_i),
        .push      (accept_rsp),
        .push_data (buf_entry),
        .pop       (pop_head),
        .flush     (redirect_i),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count),
        .head      (buf_head)
    );

    assign valid_o       = !buf_empty;
    assign PC_o          = valid_o ? buf_head.pc : '0;
    assign PC_p4_o       = valid_o ? buf_head.pc + 32'd4 : '0;
    assign Instruction_o = valid_o ? buf_head.instr : NOP_INSTR;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order, fixed-latency instruction memory model.
module tb_fetch_stage;

    localparam logic [31:0] INV = 32'h0000_0001;  // expect no valid instruction
    localparam logic [31:0] DC  = 32'h0000_0003;  // no address expectation this cycle

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        valid_o;
    logic [31:0] PC_o;
    logic [31:0] PC_p4_o;
    logic [31:0] Instruction_o;
    logic        misalign_o;

    int checks = 0;
    int failures = 0;
    int lat = 1;
    int mcyc = 0;
    logic        hs;
    logic [31:0] hs_addr;
    logic [31:0] q_addr[$];
    int          q_due[$];

    always #5 clk_i = ~clk_i;

    fetch_stage dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .valid_o       (valid_o),
        .PC_o          (PC_o),
        .PC_p4_o       (PC_p4_o),
        .Instruction_o (Instruction_o),
        .misalign_o    (misalign_o)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h3C3C_5A5B;
    endfunction

    // Memory: a grant in cycle N returns its word in cycle N+lat, one response per cycle, in order.
    always begin
        @(negedge clk_i);
        hs      = reset_i && imem_req_o && imem_gnt_i;
        hs_addr = imem_addr_o;
        @(posedge clk_i);
        #1;
        mcyc++;
        if (!reset_i) begin
            q_addr.delete();
            q_due.delete();
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end else begin
            if (hs) begin
                q_addr.push_back(hs_addr);
                q_due.push_back(mcyc - 1 + lat);
            end
            if (q_due.size() > 0 && q_due[0] <= mcyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = instr_of(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = 32'h0;
            end
        end
    end

    task automatic do_reset(input int latency);
        reset_i       = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_gnt_i    = 1'b1;
        lat           = latency;
        repeat (2) @(posedge clk_i);
        #2;
        reset_i = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        checks++;
        if ({valid_o, PC_o, PC_p4_o, Instruction_o, misalign_o} !== {1'b0, 32'h0, 32'h0, 32'h13, 1'b0}) begin
            failures++;
            $display("FAIL rst_out got v=%b pc=%h p4=%h ins=%h mis=%b want 0/0/0/00000013/0", valid_o, PC_o, PC_p4_o, Instruction_o, misalign_o);
        end
        checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0040_0000}) begin
            failures++;
            $display("FAIL rst_issue got req=%b addr=%h want 1/00400000", imem_req_o, imem_addr_o);
        end
        @(posedge clk_i);
        #2;
        reset_i = 1'b1;
        repeat (5) begin
            @(posedge clk_i);
            #2;
        end
        checks++;
        if (valid_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_valid got %b want 1", valid_o);
        end
        reset_i = 1'b0;
        #1;
        checks++;
        if ({valid_o, PC_o, PC_p4_o, Instruction_o} !== {1'b0, 32'h0, 32'h0, 32'h13}) begin
            failures++;
            $display("FAIL rst_async_out got v=%b pc=%h p4=%h ins=%h want 0/0/0/00000013", valid_o, PC_o, PC_p4_o, Instruction_o);
        end
        checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0040_0000}) begin
            failures++;
            $display("FAIL rst_async_pc got req=%b addr=%h want 1/00400000", imem_req_o, imem_addr_o);
        end
        repeat (2) @(posedge clk_i);
        #2;
        reset_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            if (k == 2) begin
                checks++;
                if ({valid_o, PC_o, Instruction_o} !== {1'b1, 32'h0040_0000, instr_of(32'h0040_0000)}) begin
                    failures++;
                    $display("FAIL rst_restart got v=%b pc=%h ins=%h want 1/00400000", valid_o, PC_o, Instruction_o);
                end
            end
            @(posedge clk_i);
            #2;
        end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        do_reset(1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            checks++;
            if (k < 2) begin
                if ({valid_o, PC_o, PC_p4_o, Instruction_o} !== {1'b0, 32'h0, 32'h0, 32'h13}) begin
                    failures++;
                    $display("FAIL stream_out cyc=%0d got v=%b pc=%h want invalid", k, valid_o, PC_o);
                end
            end else begin
                e = 32'h0040_0000 + 32'(4 * (k - 2));
                if ({valid_o, PC_o, PC_p4_o, Instruction_o} !== {1'b1, e, e + 32'd4, instr_of(e)}) begin
                    failures++;
                    $display("FAIL stream_out cyc=%0d got v=%b pc=%h p4=%h ins=%h want pc=%h", k, valid_o, PC_o, PC_p4_o, Instruction_o, e);
                end
            end
            @(posedge clk_i);
            #2;
        end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        do_reset(1);
        for (int k = 0; k < 15; k++) begin
            stall_i = (k >= 4 && k <= 8);
            @(negedge clk_i);
            if (k >= 2) begin
                if (k <= 8) e = 32'h0040_0000 + 32'(4 * ((k - 2 < 2) ? k - 2 : 2));
                else        e = 32'h0040_0008 + 32'(4 * (k - 9));
                checks++;
                if ({valid_o, PC_o, PC_p4_o, Instruction_o} !== {1'b1, e, e + 32'd4, instr_of(e)}) begin
                    failures++;
                    $display("FAIL stall_out cyc=%0d got v=%b pc=%h p4=%h ins=%h want pc=%h", k, valid_o, PC_o, PC_p4_o, Instruction_o, e);
                end
            end
            if (k >= 5 && k <= 8) begin
                checks++;
                if (imem_req_o !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_req cyc=%0d got %b want 0", k, imem_req_o);
                end
            end
            @(posedge clk_i);
            #2;
        end
        stall_i = 1'b0;
    endtask

    task automatic test_redirect();
        logic [31:0] tab [10] = '{INV, INV, INV, INV, INV, INV, INV, INV, 32'h0040_0100, 32'h0040_0104};
        do_reset(3);
        for (int k = 0; k < 10; k++) begin
            redirect_i    = (k == 2);
            redirect_pc_i = 32'h0040_0100;
            @(negedge clk_i);
            checks++;
            if (tab[k] == INV) begin
                if ({valid_o, PC_o, PC_p4_o, Instruction_o} !== {1'b0, 32'h0, 32'h0, 32'h13}) begin
                    failures++;
                    $display("FAIL redir_out cyc=%0d got v=%b pc=%h ins=%h want invalid", k, valid_o, PC_o, Instruction_o);
                end
            end else if ({valid_o, PC_o, PC_p4_o, Instruction_o} !== {1'b1, tab[k], tab[k] + 32'd4, instr_of(tab[k])}) begin
                failures++;
                $display("FAIL redir_out cyc=%0d got v=%b pc=%h p4=%h ins=%h want pc=%h", k, valid_o, PC_o, PC_p4_o, Instruction_o, tab[k]);
            end
            if (k == 3) begin
                checks++;
                if (imem_addr_o !== 32'h0040_0100) begin
                    failures++;
                    $display("FAIL redir_addr got %h want 00400100", imem_addr_o);
                end
            end
            @(posedge clk_i);
            #2;
        end
        redirect_i = 1'b0;
    endtask

    task automatic test_redirect_coincident();
        logic [31:0] tab [11] = '{INV, INV, 32'h0040_0000, 32'h0040_0004, 32'h0040_0008, 32'h0040_000C,
                                  INV, INV, 32'h0040_0200, 32'h0040_0204, 32'h0040_0208};
        do_reset(1);
        for (int k = 0; k < 11; k++) begin
            redirect_i    = (k == 5);
            redirect_pc_i = 32'h0040_0200;
            @(negedge clk_i);
            checks++;
            if (tab[k] == INV) begin
                if ({valid_o, PC_o, PC_p4_o, Instruction_o} !== {1'b0, 32'h0, 32'h0, 32'h13}) begin
                    failures++;
                    $display("FAIL coinc_out cyc=%0d got v=%b pc=%h ins=%h want invalid", k, valid_o, PC_o, Instruction_o);
                end
            end else if ({valid_o, PC_o, PC_p4_o, Instruction_o} !== {1'b1, tab[k], tab[k] + 32'd4, instr_of(tab[k])}) begin
                failures++;
                $display("FAIL coinc_out cyc=%0d got v=%b pc=%h p4=%h ins=%h want pc=%h", k, valid_o, PC_o, PC_p4_o, Instruction_o, tab[k]);
            end
            if (k == 5 || k == 6) begin
                checks++;
                if ({imem_req_o, imem_addr_o} !== {1'b1, (k == 5) ? 32'h0040_0014 : 32'h0040_0200}) begin
                    failures++;
                    $display("FAIL coinc_issue cyc=%0d got req=%b addr=%h", k, imem_req_o, imem_addr_o);
                end
            end
            @(posedge clk_i);
            #2;
        end
        redirect_i = 1'b0;
    endtask

    task automatic test_gnt_withhold();
        do_reset(1);
        for (int k = 0; k < 8; k++) begin
            imem_gnt_i = (k >= 4);
            @(negedge clk_i);
            checks++;
            if (k <= 3) begin
                if ({imem_req_o, imem_addr_o, valid_o} !== {1'b1, 32'h0040_0000, 1'b0}) begin
                    failures++;
                    $display("FAIL gnt_hold cyc=%0d got req=%b addr=%h v=%b want 1/00400000/0", k, imem_req_o, imem_addr_o, valid_o);
                end
            end else if (k == 5) begin
                if ({imem_addr_o, valid_o} !== {32'h0040_0004, 1'b0}) begin
                    failures++;
                    $display("FAIL gnt_adv got addr=%h v=%b want 00400004/0", imem_addr_o, valid_o);
                end
            end else if (k >= 6) begin
                if ({valid_o, PC_o} !== {1'b1, 32'h0040_0000 + 32'(4 * (k - 6))}) begin
                    failures++;
                    $display("FAIL gnt_out cyc=%0d got v=%b pc=%h", k, valid_o, PC_o);
                end
            end else if (valid_o !== 1'b0) begin
                failures++;
                $display("FAIL gnt_out cyc=%0d got v=%b want 0", k, valid_o);
            end
            @(posedge clk_i);
            #2;
        end
        imem_gnt_i = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] tab [10] = '{INV, INV, INV, INV, INV, INV, INV, INV, 32'h0040_0400, 32'h0040_0404};
        do_reset(3);
        for (int k = 0; k < 10; k++) begin
            redirect_i    = (k == 1 || k == 2);
            redirect_pc_i = (k == 1) ? 32'h0040_0300 : 32'h0040_0400;
            @(negedge clk_i);
            checks++;
            if (tab[k] == INV) begin
                if ({valid_o, PC_o, Instruction_o} !== {1'b0, 32'h0, 32'h13}) begin
                    failures++;
                    $display("FAIL b2b_out cyc=%0d got v=%b pc=%h want invalid", k, valid_o, PC_o);
                end
            end else if ({valid_o, PC_o, PC_p4_o, Instruction_o} !== {1'b1, tab[k], tab[k] + 32'd4, instr_of(tab[k])}) begin
                failures++;
                $display("FAIL b2b_out cyc=%0d got v=%b pc=%h ins=%h want pc=%h", k, valid_o, PC_o, Instruction_o, tab[k]);
            end
            if (k == 3 || k == 4) begin
                checks++;
                if ({imem_req_o, imem_addr_o} !== {(k == 4), 32'h0040_0400}) begin
                    failures++;
                    $display("FAIL b2b_issue cyc=%0d got req=%b addr=%h want addr 00400400", k, imem_req_o, imem_addr_o);
                end
            end
            @(posedge clk_i);
            #2;
        end
        redirect_i = 1'b0;
    endtask

    task automatic test_misalign_wrap();
        logic [31:0] tab [14] = '{INV, INV, 32'h0040_0000, 32'h0040_0004, INV, INV, 32'h0040_0100, 32'h0040_0104,
                                  32'h0040_0108, INV, INV, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        logic [31:0] atab [14] = '{DC, DC, DC, DC, 32'h0040_0100, DC, DC, DC,
                                   DC, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, DC, DC};
        do_reset(1);
        for (int k = 0; k < 14; k++) begin
            redirect_i    = (k == 3 || k == 8);
            redirect_pc_i = (k == 3) ? 32'h0040_0102 : 32'hFFFF_FFF8;
            @(negedge clk_i);
            checks++;
            if (misalign_o !== (k == 4)) begin
                failures++;
                $display("FAIL misalign cyc=%0d got %b want %b", k, misalign_o, (k == 4));
            end
            checks++;
            if (tab[k] == INV) begin
                if ({valid_o, PC_o, PC_p4_o, Instruction_o} !== {1'b0, 32'h0, 32'h0, 32'h13}) begin
                    failures++;
                    $display("FAIL wrap_out cyc=%0d got v=%b pc=%h want invalid", k, valid_o, PC_o);
                end
            end else if ({valid_o, PC_o, PC_p4_o, Instruction_o} !== {1'b1, tab[k], tab[k] + 32'd4, instr_of(tab[k])}) begin
                failures++;
                $display("FAIL wrap_out cyc=%0d got v=%b pc=%h p4=%h ins=%h want pc=%h", k, valid_o, PC_o, PC_p4_o, Instruction_o, tab[k]);
            end
            if (atab[k] != DC) begin
                checks++;
                if (imem_addr_o !== atab[k]) begin
                    failures++;
                    $display("FAIL wrap_addr cyc=%0d got %h want %h", k, imem_addr_o, atab[k]);
                end
            end
            @(posedge clk_i);
            #2;
        end
        redirect_i = 1'b0;
    endtask

    initial begin
        reset_i       = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_gnt_i    = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_coincident();
        test_gnt_withhold();
        test_back_to_back();
        test_misalign_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
